bcd_digit_driver: RTL and testbench
===================================

Name: bcd_digit_driver

Overview:
Sequential binary-to-BCD converter that sits directly upstream of the 7-segment decoders. It takes a binary value, converts it with an iterative shift-add-3 (double-dabble) loop, and presents one 5-bit digit code per display digit. Codes 0–9 are decimal digits. Code 5'h1F is the decoder's blank code and is used for leading-zero suppression. The output registers hold the previous result for the whole conversion, so the display never flickers.

Parameters:
WIDTH, 14, bit width of the binary input value
DIGITS, 4, number of decimal digits produced; the saturation limit is 10^DIGITS-1

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
value  input  WIDTH  binary value to convert, sampled on load acceptance
load  input  1  conversion request; accepted only when busy=0
blank_en  input  1  leading-zero blanking enable, sampled with value
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when digits update
ovf  output  1  set when the last accepted value exceeded 10^DIGITS-1
digits  output  5*DIGITS  digit codes; digits[4:0]=ones, digits[9:5]=tens, and so on; each lane feeds one decoder

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n), clk/rst_n.
- Reset values:
  - digits = ones lane 5'h00, all other lanes 5'h1F (display shows "0").
  - busy=0, done=0, ovf=0.
  - FSM in IDLE, iteration counter 0.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE, load=1 at edge E0:
  - Capture value into the shift register, clear the BCD accumulator (4*DIGITS bits, plus enough extra nibbles to hold 2^WIDTH-1).
  - Capture blank_en. Compute the overflow flag as value > 10^DIGITS-1.
  - Counter=0; go to SHIFT. busy=1 after E0.
- SHIFT, one iteration per cycle, exactly WIDTH cycles (edges E1..E_WIDTH). Each iteration:
  - Every BCD nibble >=5 gets +3.
  - Then {bcd, shift} shift left by 1, with the MSB of shift entering the LSB of bcd.
  - Counter increments; after WIDTH iterations go to FINISH.
- FINISH, edge E_WIDTH+1:
  - Load the digits register. done=1 for exactly this one cycle, ovf updated, busy=0, return to IDLE.
  - Latency: load acceptance to digits valid is WIDTH+1 clocks (15 for defaults). The next load is accepted at E_WIDTH+2 at the earliest.
- Overflow: when the flag is set, all lanes = 5'h09 (saturated to 9…9) regardless of blank_en, and ovf=1. Otherwise ovf=0.
- Blanking:
  - With blank_en=1, lanes above the most significant nonzero digit = 5'h1F.
  - Internal zeros are never blanked. The ones lane is never blanked, so value 0 shows "0".
  - With blank_en=0, all lanes carry 0–9.
- Handshake:
  - load while busy=1 is ignored: no queuing, no effect on the result.
  - load held high continuously triggers a new conversion every WIDTH+2 cycles.
  - load in the same cycle as FINISH is ignored, because busy is still high in that cycle.
- Stability: digits and ovf change only in FINISH. value and blank_en changes after acceptance have no effect.
- Reset mid-conversion: everything returns immediately to reset values. No done pulse is issued and the partial result is discarded.
- Arithmetic: the accumulator is wide enough that no intermediate carry is lost. Overflow detection does not depend on the BCD result.

Test Plan:
1. Reset, no load -> digits={1F,1F,1F,00}, busy=0, done=0, ovf=0.
2. value=1234, blank_en=1, pulse load at E0 -> busy high E1..E14; at E15 done=1 for one cycle, digits={01,02,03,04}, ovf=0; digits unchanged through E0..E14.
3. value=507 with blank_en=1 -> {1F,05,00,07}. The same value with blank_en=0 -> {00,05,00,07}. value=0, blank_en=1 -> {1F,1F,1F,00}.
4. value=10000 -> digits={09,09,09,09}, ovf=1. A following value=9999 -> {09,09,09,09}, ovf=0.
5. value=42 accepted, then load with value=77 at E5 -> ignored; done fires once at E15 with {1F,1F,04,02}. load held high -> done every 16 cycles.
6. rst_n low at E7 of a 1234 conversion -> immediate reset values, no done pulse; after release, a new load of 8 -> {1F,1F,1F,08} 15 cycles later.

Source files
------------

// File: rtl/bcd_digit_driver.sv
// Purpose: sequential binary-to-BCD (double-dabble) converter driving 5-bit digit codes to 7-segment decoders.
// Latency: WIDTH+1 clocks from load acceptance to digits update (done pulses on that edge).
// Backpressure: load is ignored while busy=1 (no queuing); digits and ovf hold their previous result until the update.
module bcd_digit_driver #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      value,
    input  logic                  load,
    input  logic                  blank_en,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [5*DIGITS-1:0]   digits
);

    // Number of decimal digits needed to represent 2^w-1.
    function automatic int dec_digits(input int w);
        logic [63:0] m;
        int          n;
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        n = 1;
        while (m >= 64'd10) begin
            m = m / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Display pattern "0": ones lane shows zero, all higher lanes blank.
    function automatic logic [5*DIGITS-1:0] zero_display();
        logic [5*DIGITS-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[5*i +: 5] = 5'h1F;
        end
        r[4:0] = 5'h00;
        return r;
    endfunction

    // The accumulator must hold every input value so no carry is lost,
    // even when the display itself has fewer digits.
    localparam int          BCD_NIB = (dec_digits(WIDTH) > DIGITS) ? dec_digits(WIDTH) : DIGITS;
    localparam int          BCD_W   = 4 * BCD_NIB;
    localparam int          CW      = $clog2(WIDTH + 1);
    localparam logic [63:0] LIMIT   = pow10(DIGITS) - 64'd1;
    localparam logic [5*DIGITS-1:0] RST_DIGITS = zero_display();

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    shreg;
    logic [BCD_W-1:0]    bcd;
    logic [BCD_W-1:0]    bcd_adj;
    logic                blank_q;
    logic                ovf_q;
    logic [5*DIGITS-1:0] nxt_digits;
    logic [3:0]          nib;
    logic                lead;
    logic                accept;
    logic                over_limit;

    assign busy       = (state != ST_IDLE);
    assign accept     = (state == ST_IDLE) && load;
    assign over_limit = ({{(64-WIDTH){1'b0}}, value} > LIMIT);

    // Add-3 correction on every nibble that would overflow a decimal digit on the next doubling.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_NIB; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Final lane codes: saturate on overflow, otherwise blank leading zeros scanning from the top lane down.
    always_comb begin
        nxt_digits = '0;
        lead       = blank_q;
        nib        = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = bcd[4*i +: 4];
            if (lead && (nib == 4'd0) && (i != 0)) begin
                nxt_digits[5*i +: 5] = 5'h1F;
            end else begin
                nxt_digits[5*i +: 5] = {1'b0, nib};
                lead                 = 1'b0;
            end
        end
        if (ovf_q) begin
            for (int i = 0; i < DIGITS; i++) begin
                nxt_digits[5*i +: 5] = 5'h09;
            end
        end
    end

    // Conversion FSM, datapath and output registers; outputs only change in FINISH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            shreg   <= '0;
            bcd     <= '0;
            blank_q <= 1'b0;
            ovf_q   <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            digits  <= RST_DIGITS;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shreg   <= value;
                        bcd     <= '0;
                        blank_q <= blank_en;
                        ovf_q   <= over_limit;
                        cnt     <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {bcd, shreg} <= {bcd_adj, shreg} << 1;
                    cnt          <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    digits <= nxt_digits;
                    ovf    <= ovf_q;
                    done   <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_digit_driver.sv
// Purpose: self-checking bench for bcd_digit_driver against an arithmetic reference model.
// Latency: expects digits/done WIDTH+1 clocks after load acceptance.
// Backpressure: exercises loads during busy, held load and reset mid-conversion.
module tb_bcd_digit_driver;

    localparam int W = 14;
    localparam int D = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [W-1:0]    value = '0;
    logic            load = 1'b0;
    logic            blank_en = 1'b0;
    logic            busy;
    logic            done;
    logic            ovf;
    logic [5*D-1:0]  digits;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_digit_driver #(.WIDTH(W), .DIGITS(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .load     (load),
        .blank_en (blank_en),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .digits   (digits)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits by division, saturate above 9999, blank above the most significant nonzero digit.
    function automatic logic [5*D-1:0] model(input int v, input bit b);
        logic [5*D-1:0] r;
        int dg [D];
        int p;
        int msd;
        r = '0;
        if (v > 9999) begin
            for (int i = 0; i < D; i++) r[5*i +: 5] = 5'h09;
            return r;
        end
        p   = 1;
        msd = 0;
        for (int i = 0; i < D; i++) begin
            dg[i] = (v / p) % 10;
            if (dg[i] != 0) msd = i;
            p = p * 10;
        end
        for (int i = 0; i < D; i++) begin
            if (b && i > msd) r[5*i +: 5] = 5'h1F;
            else              r[5*i +: 5] = 5'(dg[i]);
        end
        return r;
    endfunction

    // Issue one load, scramble inputs after acceptance, wait (bounded) for done.
    task automatic run_conv(input int v, input bit b, output logic [5*D-1:0] d, output logic o, output int lat);
        @(negedge clk);
        value = W'(v); blank_en = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0; value = W'($urandom); blank_en = 1'($urandom);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        d = digits;
        o = ovf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (digits !== 20'h FFC00 >> 0 && digits !== {5'h1F, 5'h1F, 5'h1F, 5'h00}) begin n_fail++; $display("FAIL reset_digits got=%h exp=%h", digits, {5'h1F, 5'h1F, 5'h1F, 5'h00}); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (digits !== {5'h1F, 5'h1F, 5'h1F, 5'h00} || busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset digits=%h busy=%b exp digits=%h busy=0", digits, busy, {5'h1F, 5'h1F, 5'h1F, 5'h00}); end
    endtask

    task automatic test_basic();
        logic [5*D-1:0] prev;
        bit stable;
        bit busy_ok;
        int lat;
        prev = digits; stable = 1'b1; busy_ok = 1'b1; lat = -1;
        value = W'(1234); blank_en = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0; value = W'($urandom); blank_en = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_e0 got=%b exp=1", busy); end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (digits !== prev) stable = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        n_checks++; if (lat != 15) begin n_fail++; $display("FAIL basic_latency got=%0d exp=15", lat); end
        n_checks++; if (digits !== model(1234, 1'b1)) begin n_fail++; $display("FAIL basic_digits got=%h exp=%h", digits, model(1234, 1'b1)); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got=%b exp=0", ovf); end
        n_checks++; if (!stable) begin n_fail++; $display("FAIL basic_hold got=changed exp=stable_until_done"); end
        n_checks++; if (!busy_ok) begin n_fail++; $display("FAIL basic_busy_window got=dropped exp=high_until_done"); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got=%b exp=0", done); end
    endtask

    task automatic test_patterns();
        int vt [8] = '{507, 507, 0, 0, 10, 100, 9999, 1000};
        bit bt [8] = '{1, 0, 1, 0, 1, 1, 1, 0};
        logic [5*D-1:0] d;
        logic o;
        int lat;
        for (int k = 0; k < 8; k++) begin
            run_conv(vt[k], bt[k], d, o, lat);
            n_checks++; if (d !== model(vt[k], bt[k]) || o !== 1'b0 || lat != 15) begin n_fail++; $display("FAIL pattern_%0d_b%0d got=%h ovf=%b lat=%0d exp=%h ovf=0 lat=15", vt[k], bt[k], d, o, lat, model(vt[k], bt[k])); end
        end
    endtask

    task automatic test_overflow();
        int vt [4] = '{10000, 9999, 16383, 10000};
        bit bt [4] = '{1, 1, 0, 0};
        logic [5*D-1:0] d;
        logic o;
        int lat;
        for (int k = 0; k < 4; k++) begin
            run_conv(vt[k], bt[k], d, o, lat);
            n_checks++; if (d !== model(vt[k], bt[k]) || o !== (vt[k] > 9999) || lat != 15) begin n_fail++; $display("FAIL overflow_%0d got=%h ovf=%b lat=%0d exp=%h ovf=%0d lat=15", vt[k], d, o, lat, model(vt[k], bt[k]), vt[k] > 9999); end
        end
    endtask

    task automatic test_ignore_busy();
        int ndone;
        int first;
        ndone = 0; first = -1;
        @(negedge clk);
        value = W'(42); blank_en = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int n = 1; n <= 4; n++) @(negedge clk);
        value = W'(77); blank_en = 1'b0; load = 1'b1;
        for (int n = 5; n <= 40; n++) begin
            @(negedge clk);
            load = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = n;
            end
        end
        n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL ignore_busy_done_count got=%0d exp=1", ndone); end
        n_checks++; if (first != 15) begin n_fail++; $display("FAIL ignore_busy_done_time got=%0d exp=15", first); end
        n_checks++; if (digits !== model(42, 1'b1)) begin n_fail++; $display("FAIL ignore_busy_digits got=%h exp=%h", digits, model(42, 1'b1)); end
    endtask

    task automatic test_back_to_back();
        int times [$];
        int v;
        v = int'($urandom_range(0, 9999));
        @(negedge clk);
        value = W'(v); blank_en = 1'b1; load = 1'b1;
        for (int n = 0; n <= 70; n++) begin
            @(negedge clk);
            if (done === 1'b1) times.push_back(n);
        end
        load = 1'b0;
        repeat (25) @(negedge clk);
        n_checks++; if (times.size() != 4) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=4", times.size()); end
        for (int k = 0; k < times.size(); k++) begin
            n_checks++; if (times[k] != 15 + 16 * k) begin n_fail++; $display("FAIL b2b_done_time_%0d got=%0d exp=%0d", k, times[k], 15 + 16 * k); end
        end
        n_checks++; if (digits !== model(v, 1'b1)) begin n_fail++; $display("FAIL b2b_digits got=%h exp=%h", digits, model(v, 1'b1)); end
    endtask

    task automatic test_reset_mid();
        int ndone;
        logic [5*D-1:0] d;
        logic o;
        int lat;
        ndone = 0;
        run_conv(10000, 1'b0, d, o, lat);
        @(negedge clk);
        value = W'(1234); blank_en = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int n = 1; n <= 6; n++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (digits !== {5'h1F, 5'h1F, 5'h1F, 5'h00} || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL reset_mid_state digits=%h busy=%b done=%b ovf=%b exp digits=%h busy=0 done=0 ovf=0", digits, busy, done, ovf, {5'h1F, 5'h1F, 5'h1F, 5'h00}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL reset_mid_no_done got=%0d exp=0", ndone); end
        run_conv(8, 1'b1, d, o, lat);
        n_checks++; if (d !== {5'h1F, 5'h1F, 5'h1F, 5'h08} || o !== 1'b0 || lat != 15) begin n_fail++; $display("FAIL reset_mid_reload got=%h ovf=%b lat=%0d exp=%h ovf=0 lat=15", d, o, lat, {5'h1F, 5'h1F, 5'h1F, 5'h08}); end
    endtask

    task automatic test_random();
        logic [5*D-1:0] d;
        logic o;
        int lat;
        int v;
        bit b;
        for (int k = 0; k < 24; k++) begin
            v = int'($urandom_range(0, (1 << W) - 1));
            if ((k % 6) == 5) v = int'($urandom_range(0, 99));
            b = 1'($urandom);
            run_conv(v, b, d, o, lat);
            n_checks++; if (d !== model(v, b) || o !== (v > 9999) || lat != 15) begin n_fail++; $display("FAIL random_%0d_b%0d got=%h ovf=%b lat=%0d exp=%h ovf=%0d lat=15", v, b, d, o, lat, model(v, b), v > 9999); end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_overflow();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
